// File: rtl/axi_isolate_ctrl_if.sv
// Control/status bundle between axi_isolate_ctrl and its power manager.
// The slave side is the controller; the master side drives requests and the isolator feedback.
interface axi_isolate_ctrl_if;
  logic       pwr_req_i;
  logic       pwr_ack_o;
  logic       isolate_o;
  logic       isolated_i;
  logic       clk_en_o;
  logic       busy_o;
  logic       timeout_o;
  logic [2:0] state_o;

  modport slave (
    input  pwr_req_i, isolated_i,
    output pwr_ack_o, isolate_o, clk_en_o, busy_o, timeout_o, state_o
  );

  modport master (
    output pwr_req_i, isolated_i,
    input  pwr_ack_o, isolate_o, clk_en_o, busy_o, timeout_o, state_o
  );
endinterface

// File: rtl/axi_isolate_ctrl.sv
// Sequences isolation and clock gating of a downstream AXI domain in response to a
// level power request; every output is decoded from registered state.
module axi_isolate_ctrl #(
  parameter int unsigned ClkDelay = 4,
  parameter int unsigned Timeout  = 1024
) (
  input logic               clk_i,
  input logic               rst_ni,
  axi_isolate_ctrl_if.slave ctrl
);

  localparam int unsigned CntMax = (ClkDelay > Timeout) ? ClkDelay : Timeout;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t CntSat      = cnt_t'(CntMax);
  localparam cnt_t DelayLast   = cnt_t'((ClkDelay > 0) ? ClkDelay - 1 : 0);
  localparam cnt_t TimeoutLast = cnt_t'((Timeout > 0) ? Timeout - 1 : 0);
  localparam bit   TimeoutEn   = (Timeout > 0);

  typedef enum logic [2:0] {
    ST_RUN         = 3'd0,
    ST_ISOLATING   = 3'd1,
    ST_GATE_WAIT   = 3'd2,
    ST_OFF         = 3'd3,
    ST_UNGATE_WAIT = 3'd4,
    ST_RELEASING   = 3'd5
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   timeout_q, timeout_d;
  logic   waiting_on_iso;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;

    unique case (state_q)
      ST_RUN: begin
        if (ctrl.pwr_req_i) state_d = ST_ISOLATING;
      end
      ST_ISOLATING: begin
        // An acknowledged isolation wins over a late withdrawal of the request.
        if (ctrl.isolated_i)      state_d = ST_GATE_WAIT;
        else if (!ctrl.pwr_req_i) state_d = ST_RELEASING;
      end
      ST_GATE_WAIT: begin
        if (cnt_q == DelayLast) state_d = ST_OFF;
      end
      ST_OFF: begin
        if (!ctrl.pwr_req_i) state_d = ST_UNGATE_WAIT;
      end
      ST_UNGATE_WAIT: begin
        if (cnt_q == DelayLast) state_d = ST_RELEASING;
      end
      ST_RELEASING: begin
        if (!ctrl.isolated_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Dwell counter restarts at every state change and saturates instead of wrapping,
  // which also guarantees the timeout compare can match only once per visit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntSat) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  assign waiting_on_iso = (state_q == ST_ISOLATING) || (state_q == ST_RELEASING);

  always_comb begin
    timeout_d = 1'b0;
    if (TimeoutEn && waiting_on_iso && (state_d == state_q) && (cnt_q == TimeoutLast)) begin
      timeout_d = 1'b1;
    end
  end

  assign ctrl.state_o   = state_q;
  assign ctrl.isolate_o = (state_q == ST_ISOLATING) || (state_q == ST_GATE_WAIT) ||
                          (state_q == ST_OFF)       || (state_q == ST_UNGATE_WAIT);
  assign ctrl.clk_en_o  = (state_q != ST_OFF);
  assign ctrl.pwr_ack_o = (state_q == ST_OFF);
  assign ctrl.busy_o    = (state_q == ST_ISOLATING)   || (state_q == ST_GATE_WAIT) ||
                          (state_q == ST_UNGATE_WAIT) || (state_q == ST_RELEASING);
  assign ctrl.timeout_o = timeout_q;

endmodule

// File: doc/axi_isolate_ctrl.md
AXI_ISOLATE_CTRL -- requirements
Module: axi_isolate_ctrl

Interface
REQ-001 SHALL have parameter ClkDelay, default 4: cycles between isolation/clock-enable edges (>=1).
REQ-002 SHALL have parameter Timeout, default 1024: max cycles to wait for isolated_i change; 0 = no timeout.
REQ-003 SHALL have port clk_i  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port pwr_req_i  in  1: level request; 1 = take downstream AXI domain offline, 0 = bring online.
REQ-006 SHALL have port pwr_ack_o  out  1: level ack; equals pwr_req_i once the requested state is fully reached.
REQ-007 SHALL have port isolate_o  out  1: drives the isolate input of the axi_isolate instance.
REQ-008 SHALL have port isolated_i  in  1: isolated output of the axi_isolate instance.
REQ-009 SHALL have port clk_en_o  out  1: clock-gate enable for the downstream domain.
REQ-010 SHALL have port busy_o  out  1: high in any transitional state.
REQ-011 SHALL have port timeout_o  out  1: one-cycle pulse when a wait exceeds Timeout.
REQ-012 SHALL have port state_o  out  3: current state encoding (REQ-014).

Function
REQ-013 SHALL use a counter of width $clog2(max(ClkDelay,Timeout)+1); loaded to 0 on every state entry; saturating, never wraps.
REQ-014 SHALL implement FSM states: RUN=0, ISOLATING=1, GATE_WAIT=2, OFF=3, UNGATE_WAIT=4, RELEASING=5.
REQ-015 RUN: isolate_o=0, clk_en_o=1, pwr_ack_o=0; pwr_req_i=1 -> ISOLATING next cycle.
REQ-016 ISOLATING: isolate_o=1, clk_en_o=1; isolated_i=1 -> GATE_WAIT; pwr_req_i=0 before isolated_i=1 -> RELEASING (abort).
REQ-017 GATE_WAIT: isolate_o=1, clk_en_o=1; after ClkDelay cycles in state -> OFF; pwr_req_i ignored here.
REQ-018 OFF: isolate_o=1, clk_en_o=0, pwr_ack_o=1; pwr_req_i=0 -> UNGATE_WAIT.
REQ-019 UNGATE_WAIT: isolate_o=1, clk_en_o=1; after ClkDelay cycles -> RELEASING; pwr_req_i ignored.
REQ-020 RELEASING: isolate_o=0, clk_en_o=1; isolated_i=0 -> RUN; pwr_req_i=1 takes effect only after RUN is reached.
REQ-021 pwr_ack_o SHALL be 1 only in OFF; busy_o=1 in states 1,2,4,5.
REQ-022 Timeout>0 in ISOLATING or RELEASING: counter reaching Timeout SHALL pulse timeout_o for exactly one cycle; FSM keeps waiting; counter holds saturated, no further pulses until state exit.
REQ-023 All outputs SHALL be registered or decoded from the state register only; no combinational path from inputs to outputs.
REQ-024 isolated_i already in target value on state entry SHALL advance FSM the following cycle (minimum 1 cycle per state).

Reset
REQ-025 During rst_ni=0: state=RUN, isolate_o=0, clk_en_o=1, pwr_ack_o=0, busy_o=0, timeout_o=0, counter=0.
REQ-026 Reset asserted mid-transition (any state) SHALL return immediately to RUN values; no pending timeout pulse survives.
REQ-027 pwr_req_i=1 held through reset release SHALL start ISOLATING on first clock after release.

Verification
REQ-028 Power-down: pwr_req_i 0->1, isolated_i rises 3 cycles after isolate_o -> clk_en_o=0 exactly ClkDelay=4 cycles after GATE_WAIT entry; pwr_ack_o=1 same cycle.
REQ-029 Power-up: from OFF, pwr_req_i=0 -> clk_en_o=1 next cycle, isolate_o=0 4 cycles later, pwr_ack_o=0 immediately, RUN after isolated_i falls.
REQ-030 Abort: pwr_req_i pulses 1 for 2 cycles, isolated_i held 0 -> ISOLATING->RELEASING->RUN, clk_en_o never 0.
REQ-031 Timeout: Timeout=16, isolated_i stuck 0 in ISOLATING -> single timeout_o pulse 16 cycles after entry, state stays 1.
REQ-032 Reset mid GATE_WAIT: rst_ni low 1 cycle -> all outputs at REQ-025 values asynchronously, state_o=0.
REQ-033 Closed loop with axi_isolate and random AXI master/slave: toggle pwr_req_i randomly for 10^5 cycles -> no AXI protocol stability assertion fails, clk_en_o=0 only while isolated_i=1.
